// File: rtl/gamepad_pmod_tx.sv
// rtl/gamepad_pmod_tx.sv - Gamepad Pmod serial transmitter (latch/clk/data), optional GAMEPAD_PMOD_TX_AUTO_EN periodic send
module gamepad_pmod_tx #(
    parameter int          CLK_DIV        = 4,
    parameter logic [11:0] ABSENT_PATTERN = 12'hFFF
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
    ,
    parameter int          FRAME_PERIOD   = 1000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] buttons0,
    input  logic        present0,
    input  logic [11:0] buttons1,
    input  logic        present1,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        pmod_latch,
    output logic        pmod_clk,
    output logic        pmod_data
);

    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLK_LO = 2'd1,
        CLK_HI = 2'd2,
        LATCH  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [23:0]     frame_q, frame_d;
    logic [4:0]      bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic            busy_d, done_d, latch_d, clk_d, data_d;
    logic            div_last;
    logic            send_any;
    logic            start_req;
    logic [23:0]     snap;

    // Slot 1 goes out first, so it occupies the upper half of the frame
    assign snap     = {present1 ? buttons1 : ABSENT_PATTERN,
                       present0 ? buttons0 : ABSENT_PATTERN};
    assign div_last = (div_q == DW'(CLK_DIV - 1));

`ifdef GAMEPAD_PMOD_TX_AUTO_EN
    localparam int AW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    logic [AW-1:0] auto_cnt;
    logic          auto_fire;
    logic          auto_pend;

    assign auto_fire = (auto_cnt == AW'(FRAME_PERIOD - 1));
    assign send_any  = send | auto_fire | auto_pend;

    // Free-running period counter; an implicit request that lands mid-frame waits in auto_pend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt  <= '0;
            auto_pend <= 1'b0;
        end else begin
            auto_cnt  <= auto_fire ? '0 : auto_cnt + AW'(1);
            auto_pend <= (auto_pend | auto_fire) & ~start_req;
        end
    end
`else
    assign send_any = send;
`endif

    // A request in the cycle that done is shown is dropped, so one long send gives spaced frames
    assign start_req = (state_q == IDLE) & send_any & ~done;

    // State, shift data, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pmod_latch <= 1'b0;
            pmod_clk   <= 1'b0;
            pmod_data  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            busy       <= busy_d;
            done       <= done_d;
            pmod_latch <= latch_d;
            pmod_clk   <= clk_d;
            pmod_data  <= data_d;
        end
    end

    // Next state and next output values; data only moves on the falling edge of pmod_clk
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        div_d   = div_q;
        busy_d  = busy;
        done_d  = 1'b0;
        latch_d = pmod_latch;
        clk_d   = pmod_clk;
        data_d  = pmod_data;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = CLK_LO;
                    frame_d = snap;
                    bit_d   = '0;
                    div_d   = '0;
                    busy_d  = 1'b1;
                    clk_d   = 1'b0;
                    data_d  = snap[23];
                end
            end
            CLK_LO: begin
                if (div_last) begin
                    div_d   = '0;
                    clk_d   = 1'b1;
                    state_d = CLK_HI;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            CLK_HI: begin
                if (div_last) begin
                    div_d = '0;
                    clk_d = 1'b0;
                    if (bit_q == 5'd23) begin
                        state_d = LATCH;
                        data_d  = 1'b0;
                        latch_d = 1'b1;
                    end else begin
                        state_d = CLK_LO;
                        bit_d   = bit_q + 5'd1;
                        data_d  = frame_q[5'd22 - bit_q];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
